// File: rtl/goal_pkg.sv
// goal_pkg: shared types and widths for the goal detector slice.
// Contents: FSM state enum, coordinate/score widths, packed goal-window struct.
// Pure declarations; no logic, no latency, no flow control.
package goal_pkg;

   localparam int COORD_W = 11;
   localparam int SCORE_W = 4;

   typedef enum logic [1:0] {
      PLAY      = 2'd0,
      HOLD      = 2'd1,
      GAME_OVER = 2'd2
   } state_t;

   // One goal window, vertical extent inclusive on both ends.
   // Fields are raw bits; consumers reinterpret them as signed coordinates.
   typedef struct packed {
      logic [COORD_W-1:0] first_y;
      logic [COORD_W-1:0] second_y;
   } goal_win_t;

endpackage

// File: rtl/goal_window_check.sv
// goal_window_check: goal-line cross plus window containment test for one side.
// Latency: purely combinational (0 cycles).
// Backpressure: none; evaluated continuously, sampled by the caller on frame strobes.
// Ports: ball_valid, ball_x, ball_y (signed ball top-left), win (goal window),
//        hit (ball fully inside the window and past this side's goal line).
// OPP_SIDE=1 tests ball_x >= GOAL_X; OPP_SIDE=0 tests right edge <= GOAL_X.
module goal_window_check
   import goal_pkg::*;
#(
   parameter bit OPP_SIDE  = 1'b1,
   parameter int BALL_SIZE = 16,
   parameter int GOAL_X    = 600
) (
   input  logic                      ball_valid,
   input  logic signed [COORD_W-1:0] ball_x,
   input  logic signed [COORD_W-1:0] ball_y,
   input  goal_win_t                 win,
   output logic                      hit
);

   // One extra bit so ball edge sums never wrap.
   localparam int SW = COORD_W + 1;
   localparam logic signed [SW-1:0] EDGE = SW'(BALL_SIZE - 1);
   localparam logic signed [SW-1:0] LINE = SW'(GOAL_X);

   logic signed [SW-1:0] x_left;
   logic signed [SW-1:0] x_right;
   logic signed [SW-1:0] y_top;
   logic signed [SW-1:0] y_bot;
   logic signed [SW-1:0] w_top;
   logic signed [SW-1:0] w_bot;
   logic                 crossed;
   logic                 in_win;

   assign x_left  = {ball_x[COORD_W-1], ball_x};
   assign y_top   = {ball_y[COORD_W-1], ball_y};
   assign w_top   = {win.first_y[COORD_W-1], win.first_y};
   assign w_bot   = {win.second_y[COORD_W-1], win.second_y};
   assign x_right = x_left + EDGE;
   assign y_bot   = y_top + EDGE;

   generate
      if (OPP_SIDE) begin : g_opp
         assign crossed = (x_left >= LINE);
      end else begin : g_team
         assign crossed = (x_right <= LINE);
      end
   endgenerate

   assign in_win = (y_top >= w_top) && (y_bot <= w_bot);
   assign hit    = ball_valid && crossed && in_win;

endmodule

// File: rtl/goal_detector.sv
// goal_detector: per-frame goal decision, score keeping, post-goal cooldown, winner.
// Latency: scores/pulses/state update on the clock edge after the sampled strobe.
// Backpressure: none; one decision per startOfFrame, inputs assumed stable then.
// Ports: clk, resetN (async active-low), startOfFrame, newGame, ballValid,
//        ballX/ballY, team/opp goal windows -> teamScores/oppScores pulses,
//        scoreTeam/scoreOpp, respawnReq pulse, inPlay, gameOver, winnerTeam.
// Option: GOAL_DETECTOR_CONFIRM_EN requires a hit on two consecutive strobes.
module goal_detector
   import goal_pkg::*;
#(
   parameter int BALL_SIZE       = 16,
   parameter int TEAM_GOAL_X     = 40,
   parameter int OPP_GOAL_X      = 600,
   parameter int COOLDOWN_FRAMES = 60,
   parameter int WIN_SCORE       = 5
) (
   input  logic                      clk,
   input  logic                      resetN,
   input  logic                      startOfFrame,
   input  logic                      newGame,
   input  logic                      ballValid,
   input  logic signed [COORD_W-1:0] ballX,
   input  logic signed [COORD_W-1:0] ballY,
   input  logic signed [COORD_W-1:0] firstY_team,
   input  logic signed [COORD_W-1:0] secondY_team,
   input  logic signed [COORD_W-1:0] firstY_opp,
   input  logic signed [COORD_W-1:0] secondY_opp,
   output logic                      teamScores,
   output logic                      oppScores,
   output logic [SCORE_W-1:0]        scoreTeam,
   output logic [SCORE_W-1:0]        scoreOpp,
   output logic                      respawnReq,
   output logic                      inPlay,
   output logic                      gameOver,
   output logic                      winnerTeam
);

   localparam int                 CD_W      = $clog2(COOLDOWN_FRAMES + 1);
   localparam logic [CD_W-1:0]    CD_LOAD   = CD_W'(COOLDOWN_FRAMES);
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
   localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);

   state_t             state;
   logic [CD_W-1:0]    cooldown;
   goal_win_t          win_team;
   goal_win_t          win_opp;
   logic               hit_opp_goal;
   logic               hit_team_goal;
   logic               go_team;
   logic               go_opp;
   logic [SCORE_W-1:0] next_team;
   logic [SCORE_W-1:0] next_opp;

   assign win_team = {firstY_team, secondY_team};
   assign win_opp  = {firstY_opp, secondY_opp};

   // Ball in the opponent goal means the team scored, and vice versa.
   goal_window_check #(
      .OPP_SIDE  (1'b1),
      .BALL_SIZE (BALL_SIZE),
      .GOAL_X    (OPP_GOAL_X)
   ) u_opp_chk (
      .ball_valid (ballValid),
      .ball_x     (ballX),
      .ball_y     (ballY),
      .win        (win_opp),
      .hit        (hit_opp_goal)
   );

   goal_window_check #(
      .OPP_SIDE  (1'b0),
      .BALL_SIZE (BALL_SIZE),
      .GOAL_X    (TEAM_GOAL_X)
   ) u_team_chk (
      .ball_valid (ballValid),
      .ball_x     (ballX),
      .ball_y     (ballY),
      .win        (win_team),
      .hit        (hit_team_goal)
   );

`ifdef GOAL_DETECTOR_CONFIRM_EN
   // Pending flags remember a hit seen on the previous strobe while in PLAY;
   // any strobe without a hit (or outside PLAY) clears them.
   logic pend_opp_goal;
   logic pend_team_goal;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         pend_opp_goal  <= 1'b0;
         pend_team_goal <= 1'b0;
      end else if (newGame) begin
         pend_opp_goal  <= 1'b0;
         pend_team_goal <= 1'b0;
      end else if (startOfFrame) begin
         pend_opp_goal  <= hit_opp_goal  && (state == PLAY);
         pend_team_goal <= hit_team_goal && (state == PLAY);
      end
   end

   assign go_team = hit_opp_goal && pend_opp_goal;
   assign go_opp  = hit_team_goal && pend_team_goal;
`else
   assign go_team = hit_opp_goal;
   assign go_opp  = hit_team_goal;
`endif

   assign next_team = (scoreTeam == SCORE_MAX) ? scoreTeam : scoreTeam + SCORE_W'(1);
   assign next_opp  = (scoreOpp  == SCORE_MAX) ? scoreOpp  : scoreOpp  + SCORE_W'(1);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state      <= PLAY;
         cooldown   <= '0;
         scoreTeam  <= '0;
         scoreOpp   <= '0;
         teamScores <= 1'b0;
         oppScores  <= 1'b0;
         respawnReq <= 1'b0;
         inPlay     <= 1'b1;
         gameOver   <= 1'b0;
         winnerTeam <= 1'b0;
      end else begin
         teamScores <= 1'b0;
         oppScores  <= 1'b0;
         respawnReq <= 1'b0;
         if (newGame) begin
            state      <= PLAY;
            cooldown   <= '0;
            scoreTeam  <= '0;
            scoreOpp   <= '0;
            respawnReq <= 1'b1;
            inPlay     <= 1'b1;
            gameOver   <= 1'b0;
            winnerTeam <= 1'b0;
         end else if (startOfFrame) begin
            case (state)
               PLAY: begin
                  // Team goal wins a same-frame tie.
                  if (go_team) begin
                     scoreTeam  <= next_team;
                     teamScores <= 1'b1;
                     inPlay     <= 1'b0;
                     if (next_team == WIN) begin
                        state      <= GAME_OVER;
                        gameOver   <= 1'b1;
                        winnerTeam <= 1'b1;
                     end else begin
                        state    <= HOLD;
                        cooldown <= CD_LOAD;
                     end
                  end else if (go_opp) begin
                     scoreOpp  <= next_opp;
                     oppScores <= 1'b1;
                     inPlay    <= 1'b0;
                     if (next_opp == WIN) begin
                        state      <= GAME_OVER;
                        gameOver   <= 1'b1;
                        winnerTeam <= 1'b0;
                     end else begin
                        state    <= HOLD;
                        cooldown <= CD_LOAD;
                     end
                  end
               end
               HOLD: begin
                  // The strobe that sees 1 is the last of the cooldown.
                  if (cooldown <= CD_W'(1)) begin
                     state      <= PLAY;
                     cooldown   <= '0;
                     respawnReq <= 1'b1;
                     inPlay     <= 1'b1;
                  end else begin
                     cooldown <= cooldown - CD_W'(1);
                  end
               end
               GAME_OVER: begin
                  state <= GAME_OVER;
               end
               default: begin
                  state  <= PLAY;
                  inPlay <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_goal_detector.sv
// tb_goal_detector: directed checks of scoring, cooldown, game over, reset abort.
// A second instance with the team line moved far right exercises same-frame priority.
module tb_goal_detector;
   import goal_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                      resetN;
   logic                      startOfFrame;
   logic                      newGame;
   logic                      ballValid;
   logic signed [COORD_W-1:0] ballX;
   logic signed [COORD_W-1:0] ballY;
   logic signed [COORD_W-1:0] firstY_team;
   logic signed [COORD_W-1:0] secondY_team;
   logic signed [COORD_W-1:0] firstY_opp;
   logic signed [COORD_W-1:0] secondY_opp;

   logic               teamScores, oppScores, respawnReq, inPlay, gameOver, winnerTeam;
   logic [SCORE_W-1:0] scoreTeam, scoreOpp;
   logic               p_teamScores, p_oppScores, p_respawnReq, p_inPlay, p_gameOver, p_winnerTeam;
   logic [SCORE_W-1:0] p_scoreTeam, p_scoreOpp;

   goal_detector dut (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .newGame      (newGame),
      .ballValid    (ballValid),
      .ballX        (ballX),
      .ballY        (ballY),
      .firstY_team  (firstY_team),
      .secondY_team (secondY_team),
      .firstY_opp   (firstY_opp),
      .secondY_opp  (secondY_opp),
      .teamScores   (teamScores),
      .oppScores    (oppScores),
      .scoreTeam    (scoreTeam),
      .scoreOpp     (scoreOpp),
      .respawnReq   (respawnReq),
      .inPlay       (inPlay),
      .gameOver     (gameOver),
      .winnerTeam   (winnerTeam)
   );

   goal_detector #(.TEAM_GOAL_X(1000)) dut_pri (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .newGame      (newGame),
      .ballValid    (ballValid),
      .ballX        (ballX),
      .ballY        (ballY),
      .firstY_team  (firstY_team),
      .secondY_team (secondY_team),
      .firstY_opp   (firstY_opp),
      .secondY_opp  (secondY_opp),
      .teamScores   (p_teamScores),
      .oppScores    (p_oppScores),
      .scoreTeam    (p_scoreTeam),
      .scoreOpp     (p_scoreOpp),
      .respawnReq   (p_respawnReq),
      .inPlay       (p_inPlay),
      .gameOver     (p_gameOver),
      .winnerTeam   (p_winnerTeam)
   );

   int checks   = 0;
   int failures = 0;
   int tp, op, rr, tp2, op2;
   int resp_cnt, resp_idx;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One strobe; pulses caused by it are captured on the following negedge.
   task automatic frame();
      @(negedge clk) startOfFrame = 1'b1;
      @(negedge clk) startOfFrame = 1'b0;
      tp  = int'(teamScores);
      op  = int'(oppScores);
      rr  = int'(respawnReq);
      tp2 = int'(p_teamScores);
      op2 = int'(p_oppScores);
      @(negedge clk);
   endtask

   task automatic frames(input int n);
      resp_cnt = 0;
      resp_idx = 0;
      for (int i = 1; i <= n; i++) begin
         frame();
         if (rr != 0) begin
            resp_cnt++;
            if (resp_idx == 0) resp_idx = i;
         end
      end
   endtask

   task automatic goal_frame(input int x, input int y);
      ballX = COORD_W'(x);
      ballY = COORD_W'(y);
`ifdef GOAL_DETECTOR_CONFIRM_EN
      frame();
`endif
      frame();
   endtask

   task automatic place_neutral();
      ballX = 11'sd300;
      ballY = 11'sd220;
   endtask

   task automatic new_game();
      @(negedge clk) newGame = 1'b1;
      @(negedge clk) newGame = 1'b0;
      rr = int'(respawnReq);
      @(negedge clk);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_teamScores"}, int'(teamScores), 0);
      check({tag, "_oppScores"},  int'(oppScores),  0);
      check({tag, "_scoreTeam"},  int'(scoreTeam),  0);
      check({tag, "_scoreOpp"},   int'(scoreOpp),   0);
      check({tag, "_respawn"},    int'(respawnReq), 0);
      check({tag, "_inPlay"},     int'(inPlay),     1);
      check({tag, "_gameOver"},   int'(gameOver),   0);
      check({tag, "_winner"},     int'(winnerTeam), 0);
   endtask

   initial begin
      resetN       = 1'b0;
      startOfFrame = 1'b0;
      newGame      = 1'b0;
      ballValid    = 1'b1;
      firstY_team  = 11'sd150;
      secondY_team = 11'sd214;
      firstY_opp   = 11'sd205;
      secondY_opp  = 11'sd269;
      place_neutral();
      repeat (3) @(negedge clk);
      check_reset_vals("rst");
      resetN = 1'b1;
      @(negedge clk);

      // Team goal, then exactly 60 strobes to respawn.
      goal_frame(610, 220);
      check("t1_teamScores", tp, 1);
      check("t1_oppScores", op, 0);
      check("t1_scoreTeam", int'(scoreTeam), 1);
      check("t1_hold_inPlay", int'(inPlay), 0);
      check("t1_gameOver", int'(gameOver), 0);
      place_neutral();
      frames(70);
      check("t1_respawn_idx", resp_idx, 60);
      check("t1_respawn_cnt", resp_cnt, 1);
      check("t1_back_inPlay", int'(inPlay), 1);

      // Bottom edge 275 falls outside 205..269: bounce, no goal.
      goal_frame(610, 260);
      check("t2_teamScores", tp, 0);
      check("t2_scoreTeam", int'(scoreTeam), 1);
      check("t2_inPlay", int'(inPlay), 1);

      // Opponent goal; repeat hit in HOLD ignored.
      goal_frame(20, 160);
      check("t3_oppScores", op, 1);
      check("t3_teamScores", tp, 0);
      check("t3_scoreOpp", int'(scoreOpp), 1);
      check("t3_inPlay", int'(inPlay), 0);
      frame();
      check("t3_hold_ignored", op, 0);
      check("t3_hold_scoreOpp", int'(scoreOpp), 1);
      place_neutral();
      frames(59);
      check("t3_respawn_cnt", resp_cnt, 1);
      check("t3_respawn_idx", resp_idx, 59);
      check("t3_inPlay", int'(inPlay), 1);

      // Climb to 4, then the winning goal.
      for (int k = 0; k < 3; k++) begin
         goal_frame(610, 220);
         place_neutral();
         frames(60);
      end
      check("t4_score4", int'(scoreTeam), 4);
      check("t4_inPlay4", int'(inPlay), 1);
      goal_frame(610, 220);
      check("t4_teamScores", tp, 1);
      check("t4_score5", int'(scoreTeam), 5);
      check("t4_gameOver", int'(gameOver), 1);
      check("t4_winner", int'(winnerTeam), 1);
      check("t4_inPlay", int'(inPlay), 0);
      frames(70);
      check("t4_no_respawn", resp_cnt, 0);
      check("t4_sticky_score", int'(scoreTeam), 5);
      check("t4_sticky_over", int'(gameOver), 1);
      new_game();
      check("t4_ng_respawn", rr, 1);
      check("t4_ng_scoreTeam", int'(scoreTeam), 0);
      check("t4_ng_scoreOpp", int'(scoreOpp), 0);
      check("t4_ng_inPlay", int'(inPlay), 1);
      check("t4_ng_gameOver", int'(gameOver), 0);

      // Reset during HOLD with cooldown at 30.
      goal_frame(610, 220);
      check("t6_scored", int'(scoreTeam), 1);
      place_neutral();
      frames(30);
      check("t6_no_early_respawn", resp_cnt, 0);
      @(negedge clk) resetN = 1'b0;
      #1;
      check_reset_vals("midhold");
      @(negedge clk) resetN = 1'b1;
      frames(80);
      check("t6_no_respawn", resp_cnt, 0);
      check("t6_inPlay", int'(inPlay), 1);
      check("t6_scoreTeam", int'(scoreTeam), 0);

      // Single-frame hit handling.
      new_game();
      ballX = 11'sd610;
      ballY = 11'sd220;
`ifdef GOAL_DETECTOR_CONFIRM_EN
      frame();
      check("cf_single_pulse", tp, 0);
      place_neutral();
      frame();
      check("cf_single_score", int'(scoreTeam), 0);
      ballX = 11'sd610;
      ballY = 11'sd220;
      frame();
      check("cf_first_of_two", tp, 0);
      frame();
      check("cf_second_pulse", tp, 1);
      check("cf_score", int'(scoreTeam), 1);
`else
      frame();
      check("sf_pulse", tp, 1);
      check("sf_score", int'(scoreTeam), 1);
`endif

      // Both hits on one frame: team goal wins.
      new_game();
      firstY_team  = 11'sd205;
      secondY_team = 11'sd269;
      goal_frame(610, 220);
      check("pri_teamScores", tp2, 1);
      check("pri_oppScores", op2, 0);
      check("pri_scoreTeam", int'(p_scoreTeam), 1);
      check("pri_scoreOpp", int'(p_scoreOpp), 0);
      check("pri_inPlay", int'(p_inPlay), 0);
      check("pri_respawn", int'(p_respawnReq), 0);
      check("pri_gameOver", int'(p_gameOver), 0);
      check("pri_winner", int'(p_winnerTeam), 0);
      check("pri_main_team", tp, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
